// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: fetch FSM encoding and instruction constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/ack bus and fetch-to-decode output bundle.
interface ifetch_if #(
    parameter int n  = 8,
    parameter int IW = 32
);
    logic          imem_req;
    logic [n-1:0]  imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [IW-1:0] if_instr;
    logic [n-1:0]  if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, if_ready
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: issues imem requests for pc_in, buffers one instruction
// for decode, advances the PC only on a completed fetch and squashes work on redirect.
module ifetch
    import riscv_pkg::*;
#(
    parameter int n  = 8,
    parameter int IW = INSTR_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [n-1:0] pc_in,
    output logic         pc_en,
    input  logic         flush,
    ifetch_if.master     bus
);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    logic [n-1:0] addr_r;
    logic         load_s;
    logic         latch_s;
    logic         consume_s;

    // Next state, memory request, PC enable and output-register control.
    always_comb begin
        state_nxt_s   = state_r;
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc_in;
        pc_en         = 1'b0;
        load_s        = 1'b0;
        latch_s       = 1'b0;
        consume_s     = bus.if_valid && bus.if_ready;
        case (state_r)
            BOOT: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                bus.imem_req = !bus.if_valid || bus.if_ready;
                if (flush) begin
                    pc_en = 1'b1;
                    // An outstanding request cannot be withdrawn, so its data is drained in DROP.
                    if (bus.imem_req && !bus.imem_ack) begin
                        latch_s     = 1'b1;
                        state_nxt_s = DROP;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end else if (bus.imem_req && bus.imem_ack) begin
                    pc_en  = 1'b1;
                    load_s = 1'b1;
                end else begin
                    pc_en = 1'b0;
                end
            end
            DROP: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = addr_r;
                if (flush) begin
                    pc_en = 1'b1;
                end else begin
                    pc_en = 1'b0;
                end
                if (bus.imem_ack) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // FSM state, squashed-request address and the decode output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= BOOT;
            addr_r       <= '0;
            bus.if_valid <= 1'b0;
            bus.if_instr <= IW'(NOP_INSTR);
            bus.if_pc    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (latch_s) begin
                addr_r <= pc_in;
            end
            if (flush && (state_r != BOOT)) begin
                bus.if_valid <= 1'b0;
            end else if (load_s) begin
                bus.if_valid <= 1'b1;
                bus.if_instr <= bus.imem_rdata;
                bus.if_pc    <= pc_in;
            end else if (consume_s) begin
                bus.if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: PC and wait-state memory models, hand-computed expectations.
module tb_ifetch;
    localparam int N  = 8;
    localparam int IW = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] pc;
    logic         pc_en;
    logic         flush = 1'b0;
    logic [N-1:0] target = 8'h00;
    int           waits = 0;
    int           cnt;
    int           checks = 0;
    int           failures = 0;

    ifetch_if #(.n(N), .IW(IW)) bus ();

    ifetch #(.n(N), .IW(IW)) dut (
        .clock (clock),
        .reset (reset),
        .pc_in (pc),
        .pc_en (pc_en),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.imem_ack   = bus.imem_req && (cnt == waits);
    assign bus.imem_rdata = 32'h0000_0100 + {24'h000000, bus.imem_addr};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= 8'h00;
            cnt <= 0;
        end else begin
            if (pc_en) pc <= flush ? target : pc + 8'h01;
            if (!bus.imem_req || bus.imem_ack) cnt <= 0;
            else cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.if_ready = 1'b1;
        #12;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_instr", bus.if_instr, 32'h0000_0013);
        chk("rst_if_pc", 32'(bus.if_pc), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("boot_req", 32'(bus.imem_req), 32'd0);
        chk("boot_pc_en", 32'(pc_en), 32'd0);

        // zero-wait streaming
        cyc();
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", 32'(bus.imem_addr), 32'd0);
        chk("first_pc_en", 32'(pc_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("zw_valid", 32'(bus.if_valid), 32'd1);
            chk("zw_if_pc", 32'(bus.if_pc), 32'(i));
            chk("zw_instr", bus.if_instr, 32'h100 + 32'(i));
            chk("zw_pc_en", 32'(pc_en), 32'd1);
            chk("zw_addr", 32'(bus.imem_addr), 32'(i + 1));
        end

        // three wait states on addr 4
        waits = 3;
        #1;
        chk("ws_req0", 32'(bus.imem_req), 32'd1);
        chk("ws_addr0", 32'(bus.imem_addr), 32'd4);
        chk("ws_pc_en0", 32'(pc_en), 32'd0);
        for (int j = 1; j < 4; j++) begin
            cyc();
            chk("ws_req", 32'(bus.imem_req), 32'd1);
            chk("ws_addr", 32'(bus.imem_addr), 32'd4);
            chk("ws_pc_en", 32'(pc_en), (j == 3) ? 32'd1 : 32'd0);
            chk("ws_valid", 32'(bus.if_valid), 32'd0);
        end
        cyc();
        chk("ws_done_valid", 32'(bus.if_valid), 32'd1);
        chk("ws_done_if_pc", 32'(bus.if_pc), 32'd4);
        chk("ws_done_instr", bus.if_instr, 32'h104);
        chk("ws_done_addr", 32'(bus.imem_addr), 32'd5);

        // decode back-pressure for 5 cycles
        waits = 0;
        bus.if_ready = 1'b0;
        #1;
        chk("bp_req0", 32'(bus.imem_req), 32'd0);
        chk("bp_pc_en0", 32'(pc_en), 32'd0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("bp_req", 32'(bus.imem_req), 32'd0);
            chk("bp_pc_en", 32'(pc_en), 32'd0);
            chk("bp_valid", 32'(bus.if_valid), 32'd1);
            chk("bp_if_pc", 32'(bus.if_pc), 32'd4);
            chk("bp_instr", bus.if_instr, 32'h104);
        end
        bus.if_ready = 1'b1;
        #1;
        chk("bp_resume_req", 32'(bus.imem_req), 32'd1);
        chk("bp_resume_addr", 32'(bus.imem_addr), 32'd5);
        chk("bp_resume_pc_en", 32'(pc_en), 32'd1);
        cyc();
        chk("bp_after_if_pc", 32'(bus.if_pc), 32'd5);
        chk("bp_after_instr", bus.if_instr, 32'h105);

        // flush while the request for addr 6 waits; ack two cycles later
        waits = 2;
        #1;
        chk("fl_wait_pc_en", 32'(pc_en), 32'd0);
        flush = 1'b1;
        target = 8'h20;
        #1;
        chk("fl_pc_en", 32'(pc_en), 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("drop_req1", 32'(bus.imem_req), 32'd1);
        chk("drop_addr1", 32'(bus.imem_addr), 32'd6);
        chk("drop_pc_en1", 32'(pc_en), 32'd0);
        chk("drop_valid1", 32'(bus.if_valid), 32'd0);
        cyc();
        chk("drop_addr2", 32'(bus.imem_addr), 32'd6);
        chk("drop_ack2", 32'(bus.imem_ack), 32'd1);
        chk("drop_pc_en2", 32'(pc_en), 32'd0);
        chk("drop_valid2", 32'(bus.if_valid), 32'd0);
        cyc();
        chk("redir_valid", 32'(bus.if_valid), 32'd0);
        chk("redir_req", 32'(bus.imem_req), 32'd1);
        chk("redir_addr", 32'(bus.imem_addr), 32'h20);
        waits = 0;
        #1;
        chk("redir_pc_en", 32'(pc_en), 32'd1);
        cyc();
        chk("redir_if_pc", 32'(bus.if_pc), 32'h20);
        chk("redir_instr", bus.if_instr, 32'h120);

        // flush coinciding with the ack for addr 0x21
        flush = 1'b1;
        target = 8'h40;
        #1;
        chk("flack_pc_en", 32'(pc_en), 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("flack_valid", 32'(bus.if_valid), 32'd0);
        chk("flack_if_pc", 32'(bus.if_pc), 32'h20);
        chk("flack_addr", 32'(bus.imem_addr), 32'h40);
        cyc();
        chk("flack_next_if_pc", 32'(bus.if_pc), 32'h40);
        chk("flack_next_instr", bus.if_instr, 32'h140);

        // reset while draining in DROP
        waits = 3;
        flush = 1'b1;
        target = 8'h60;
        #1;
        chk("rd_pc_en", 32'(pc_en), 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("rd_drop_req", 32'(bus.imem_req), 32'd1);
        chk("rd_drop_addr", 32'(bus.imem_addr), 32'h41);
        #2 reset = 1'b1;
        #1;
        chk("rd_req", 32'(bus.imem_req), 32'd0);
        chk("rd_pc_en_rst", 32'(pc_en), 32'd0);
        chk("rd_valid", 32'(bus.if_valid), 32'd0);
        chk("rd_if_pc", 32'(bus.if_pc), 32'd0);
        chk("rd_instr", bus.if_instr, 32'h0000_0013);
        @(posedge clock);
        #1;
        reset = 1'b0;
        waits = 0;
        #1;
        chk("rd_boot_req", 32'(bus.imem_req), 32'd0);
        cyc();
        chk("rd_first_req", 32'(bus.imem_req), 32'd1);
        chk("rd_first_addr", 32'(bus.imem_addr), 32'd0);
        chk("rd_first_pc_en", 32'(pc_en), 32'd1);
        cyc();
        chk("rd_restart_valid", 32'(bus.if_valid), 32'd1);
        chk("rd_restart_if_pc", 32'(bus.if_pc), 32'd0);
        chk("rd_restart_instr", bus.if_instr, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage sitting directly downstream of the program counter: it takes the current word address from the PC, issues a req/ack transaction to instruction memory, and holds the returned instruction in a one-entry output register for decode. It generates the PC advance enable, so the PC only moves when an instruction has actually been fetched. It also discards in-flight or buffered instructions when execute redirects control flow (branch, JAL, JALR).

## Interface
- `n`, default 8: PC / instruction-memory address width; word address, one instruction per address.
- `IW`, default 32: instruction width.

- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  n  current PC (`pcOut` of the PC stage).
- `pc_en`  out  1  PC update enable; the PC loads its next value on the clock edge where this is 1.
- `flush`  in  1  redirect from execute; the PC loads a new target this cycle.
- `imem_req`  out  1  memory request, level; held until accepted.
- `imem_addr`  out  n  memory word address; stable while `imem_req`=1 and `imem_ack`=0.
- `imem_ack`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  IW  instruction word.
- `if_valid`  out  1  output register holds a valid instruction.
- `if_ready`  in  1  decode consumes the instruction this cycle when `if_valid`=1.
- `if_instr`  out  IW  fetched instruction.
- `if_pc`  out  n  address the instruction was fetched from.

## Operation
- Transfer: a memory transfer occurs when `imem_req`=1 and `imem_ack`=1. A consume occurs when `if_valid`=1 and `if_ready`=1.
- FSM has three states: BOOT, FETCH, DROP.
- BOOT is entered on reset. In BOOT, `imem_req`=0 and `pc_en`=0. The next state is always FETCH.
- FETCH:
  - `imem_req` = !`if_valid` || `if_ready`.
  - `imem_addr` = `pc_in`.
  - On transfer without flush: `if_instr`<=`imem_rdata`, `if_pc`<=`pc_in`, `if_valid`<=1, `pc_en`=1.
  - On a consume without a transfer: `if_valid`<=0.
- DROP:
  - `imem_req`=1, `imem_addr`=`addr_q` (the latched address).
  - On `imem_ack`, the data is discarded and the next state is FETCH.
  - `if_valid` stays 0.
- `flush` has priority over everything else:
  - `if_valid`<=0 and `pc_en`=1 in any state except BOOT.
  - FETCH with `imem_req`=1 and `imem_ack`=0: `addr_q`<=`pc_in`, next state DROP. A request once raised is never withdrawn.
  - FETCH with a transfer in the same cycle: the data is discarded and the state stays FETCH.
  - DROP: stays DROP; if `imem_ack`=1 in the same cycle, go to FETCH instead.
- `pc_en`=0 in all other cases, so the PC holds while memory stalls or decode back-pressures.
- Arithmetic: none beyond register loads. Address wrap-around is owned by the PC; `ifetch` passes `pc_in` through unchanged.

## Timing
- Reset values: state BOOT, `imem_req` 0, `pc_en` 0, `if_valid` 0, `if_instr` = NOP (32'h00000013), `if_pc` 0, `addr_q` 0.
- Asserting `reset` mid-transaction drops `imem_req` immediately. Instruction memory shares the same reset.
- Latency with a zero-wait memory (ack in the request cycle):
  - The instruction is visible on `if_instr` one cycle after the request.
  - Throughput is one instruction per cycle while `if_ready`=1.
- With wait states, `imem_req`, `imem_addr` and `pc_en`=0 hold until ack.
- The first request occurs in the second cycle after `reset` deasserts.
- After `flush`, the first request for the target address happens:
  - the next cycle if nothing is outstanding, or
  - the cycle after the DROP ack otherwise.

## Structure
- The shared package `riscv_pkg` holds:
  - the `fetch_state_t` enum (BOOT, FETCH, DROP),
  - `INSTR_W` = 32,
  - `NOP_INSTR` = 32'h00000013.
- Single module with no sub-modules. The output register and the FSM live in the same `always_ff` with asynchronous reset; request and enable logic is `always_comb`.

## Test plan
- Reset, then zero-wait memory returning addr+0x100, `if_ready`=1 → `imem_req` rises in the 2nd cycle; `if_pc` = 0,1,2,… with `if_instr` = 0x100,0x101,… on consecutive cycles; `pc_en`=1 every cycle.
- Memory with 3 wait states → `imem_addr` and `imem_req` stable for 4 cycles; `pc_en` pulses only in the ack cycle; one instruction every 4 cycles.
- `if_ready`=0 for 5 cycles with `if_valid`=1 → `imem_req`=0 and `pc_en`=0; `if_instr` and `if_pc` are unchanged; fetch resumes the cycle `if_ready` returns.
- `flush` while a request to addr 5 is waiting (ack 2 cycles later), PC then 0x20 → state DROP; `imem_addr` stays 5 until ack; data is dropped; the next request is 0x20; `if_valid` never shows addr 5.
- `flush` in the same cycle as an ack for addr 7 → the addr 7 data is discarded; `if_valid`=0 next cycle; the next request uses the redirected PC.
- `reset` asserted during DROP → `imem_req`, `if_valid` and `pc_en` go to 0 asynchronously; after release the fetch restarts from addr 0 via BOOT.
